// File: rtl/rr_bank_arbiter_pkg.sv
// Shared definitions for the round-robin bank arbiter: request field layout,
// derived width helpers and the response pipeline tag.
package rr_sched_pkg;

    // Request layout, LSB first: {addr, value, wr, valid}
    localparam int unsigned VALID_BIT = 0;
    localparam int unsigned WR_BIT    = 1;
    localparam int unsigned VALUE_LSB = 2;

    // Consumer ids are carried at a fixed width; supports up to 256 consumers
    localparam int unsigned ID_WIDTH = 8;

    typedef struct packed {
        logic                is_read;
        logic [ID_WIDTH-1:0] id;
    } rsp_tag_t;

    function automatic int unsigned addr_lsb(input int unsigned value_width);
        return VALUE_LSB + value_width;
    endfunction

    function automatic int unsigned req_width(input int unsigned addr_width,
                                              input int unsigned value_width);
        return addr_width + value_width + 2;
    endfunction

    function automatic int unsigned plm_input_width(input int unsigned addr_width,
                                                    input int unsigned value_width,
                                                    input int unsigned bank_bits);
        return addr_width - bank_bits + value_width + 1;
    endfunction

endpackage

// File: rtl/rr_bank_arbiter_priority_pick.sv
// Rotating priority picker: first set bit of eligible at or above pivot,
// wrapping modulo N. Double-width rotate followed by a priority encoder.
module rr_priority_pick
    import rr_sched_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]         eligible,
    input  logic [$clog2(N)-1:0] pivot,
    output logic [N-1:0]         onehot,
    output logic [$clog2(N)-1:0] index,
    output logic                 any
);

    localparam int unsigned IW  = $clog2(N);
    localparam logic [IW:0] N_W = (IW+1)'(N);

    logic [N-1:0] rot;
    logic [IW:0]  offset;
    logic [IW:0]  sum;
    logic         found;

    always_comb begin
        rot    = N'({eligible, eligible} >> pivot);
        offset = '0;
        found  = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found  = 1'b1;
                offset = (IW+1)'(k);
            end
        end
        any = found;
        // Map the rotated offset back to a consumer index; explicit wrap
        // keeps non-power-of-2 N correct.
        sum = {1'b0, pivot} + offset;
        if (sum >= N_W) begin
            sum = sum - N_W;
        end
        index  = sum[IW-1:0];
        onehot = found ? (N'(1) << index) : '0;
    end

endmodule

// File: rtl/rr_bank_arbiter.sv
// Work-conserving round-robin arbiter for one port of one PLM bank, with a
// read response return path. Optional perf counters: RR_BANK_ARB_PERF_EN.
module rr_bank_arbiter
    import rr_sched_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned VALUE_WIDTH = 8,
    parameter int unsigned NCONSUMERS  = 2,
    parameter int unsigned NBANKS      = 1,
    parameter int unsigned BANK_ID     = 0,
    parameter int unsigned PIVOT_INIT  = 0,
    parameter int unsigned PLM_LATENCY = 1
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [NCONSUMERS*req_width(ADDR_WIDTH, VALUE_WIDTH)-1:0] requests,
    input  logic                                          hold,
    output logic [NCONSUMERS-1:0]                         acks,
    output logic                                          plm_en,
    output logic [plm_input_width(ADDR_WIDTH, VALUE_WIDTH, $clog2(NBANKS))-1:0] plm_input,
    input  logic [VALUE_WIDTH-1:0]                        plm_output,
    output logic [NCONSUMERS-1:0]                         rsp_valid,
    output logic [VALUE_WIDTH-1:0]                        rsp_data,
    output logic [31:0]                                   grant_count,
    output logic [31:0]                                   conflict_count
);

    localparam int unsigned NBB    = $clog2(NBANKS);
    localparam int unsigned REQ_W  = req_width(ADDR_WIDTH, VALUE_WIDTH);
    localparam int unsigned PIN_W  = plm_input_width(ADDR_WIDTH, VALUE_WIDTH, NBB);
    localparam int unsigned LAW    = ADDR_WIDTH - NBB;
    localparam int unsigned A_LSB  = addr_lsb(VALUE_WIDTH);
    localparam int unsigned IW     = $clog2(NCONSUMERS);

    logic [NCONSUMERS-1:0] eligible;
    logic [PIN_W-1:0]      payload [NCONSUMERS];

    genvar g;
    generate
        for (g = 0; g < NCONSUMERS; g++) begin : g_cons
            if (NBB == 0) begin : g_single_bank
                assign eligible[g] = requests[g*REQ_W + VALID_BIT];
            end else begin : g_multi_bank
                assign eligible[g] = requests[g*REQ_W + VALID_BIT] &&
                    (requests[g*REQ_W + A_LSB + LAW +: NBB] == NBB'(BANK_ID));
            end
            assign payload[g] = {requests[g*REQ_W + A_LSB +: LAW],
                                 requests[g*REQ_W + VALUE_LSB +: VALUE_WIDTH],
                                 requests[g*REQ_W + WR_BIT]};
        end
    endgenerate

    logic [IW-1:0]         pivot;
    logic [NCONSUMERS-1:0] win_oh;
    logic [IW-1:0]         win_idx;
    logic                  win_any;
    logic                  grant;
    logic                  win_wr;

    rr_priority_pick #(
        .N (NCONSUMERS)
    ) u_pick (
        .eligible (eligible),
        .pivot    (pivot),
        .onehot   (win_oh),
        .index    (win_idx),
        .any      (win_any)
    );

    // Gating with reset keeps acks/plm_en low for the whole reset window
    assign grant     = win_any & ~hold & reset;
    assign win_wr    = payload[win_idx][0];
    assign acks      = grant ? win_oh : '0;
    assign plm_en    = grant;
    assign plm_input = grant ? payload[win_idx] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pivot <= IW'(PIVOT_INIT);
        end else if (grant) begin
            if (win_idx == IW'(NCONSUMERS - 1)) begin
                pivot <= '0;
            end else begin
                pivot <= win_idx + 1'b1;
            end
        end
    end

    rsp_tag_t pipe [PLM_LATENCY];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned s = 0; s < PLM_LATENCY; s++) begin
                pipe[s] <= '0;
            end
        end else begin
            pipe[0] <= '{is_read: grant & ~win_wr, id: ID_WIDTH'(win_idx)};
            for (int unsigned s = 1; s < PLM_LATENCY; s++) begin
                pipe[s] <= pipe[s-1];
            end
        end
    end

    rsp_tag_t last;
    assign last      = pipe[PLM_LATENCY-1];
    assign rsp_valid = last.is_read ? (NCONSUMERS'(1) << last.id) : '0;
    assign rsp_data  = last.is_read ? plm_output : '0;

`ifdef RR_BANK_ARB_PERF_EN
    logic        conflict;
    logic [31:0] grant_cnt;
    logic [31:0] conflict_cnt;

    // Clearing the lowest set bit leaves a nonzero vector iff two or more are set
    assign conflict = ((eligible & (eligible - 1'b1)) != '0) & ~hold;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_cnt    <= '0;
            conflict_cnt <= '0;
        end else begin
            if (grant && grant_cnt != '1) begin
                grant_cnt <= grant_cnt + 1'b1;
            end
            if (conflict && conflict_cnt != '1) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
        end
    end

    assign grant_count    = grant_cnt;
    assign conflict_count = conflict_cnt;
`else
    assign grant_count    = '0;
    assign conflict_count = '0;
`endif

endmodule

// File: tb/tb_rr_bank_arbiter.sv
// Randomized and directed bench for rr_bank_arbiter (4 consumers, 2 banks,
// serving bank 1, PLM latency 2) against a cycle-level behavioural model.
module tb_rr_bank_arbiter;

    localparam int AW    = 4;
    localparam int VW    = 8;
    localparam int NC    = 4;
    localparam int NB    = 2;
    localparam int BID   = 1;
    localparam int PINIT = 0;
    localparam int LAT   = 2;
    localparam int REQ_W = AW + VW + 2;
    localparam int PIN_W = AW - 1 + VW + 1;
    localparam int SPAN  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NC*REQ_W-1:0] requests;
    logic              hold;
    logic [NC-1:0]     acks;
    logic              plm_en;
    logic [PIN_W-1:0]  plm_input;
    logic [VW-1:0]     plm_output;
    logic [NC-1:0]     rsp_valid;
    logic [VW-1:0]     rsp_data;
    logic [31:0]       grant_count;
    logic [31:0]       conflict_count;

    rr_bank_arbiter #(
        .ADDR_WIDTH  (AW),
        .VALUE_WIDTH (VW),
        .NCONSUMERS  (NC),
        .NBANKS      (NB),
        .BANK_ID     (BID),
        .PIVOT_INIT  (PINIT),
        .PLM_LATENCY (LAT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .requests       (requests),
        .hold           (hold),
        .acks           (acks),
        .plm_en         (plm_en),
        .plm_input      (plm_input),
        .plm_output     (plm_output),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .grant_count    (grant_count),
        .conflict_count (conflict_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Consumer-side request state
    int r_addr [NC];
    int r_val  [NC];
    int r_wr   [NC];
    int r_vld  [NC];

    // Reference model state
    int     pivot;
    int     sched_valid [8];
    int     sched_id    [8];
    int     cyc;
    longint gcnt;
    longint ccnt;
    int     waitc [NC];
    int     last_win;

    task automatic new_req(input int i);
        r_vld[i]  = ($urandom_range(0, 3) != 0);
        r_addr[i] = $urandom_range(0, 15);
        r_val[i]  = $urandom_range(0, 255);
        r_wr[i]   = $urandom_range(0, 1);
        waitc[i]  = 0;
    endtask

    task automatic set_req(input int i, input int vld, input int addr, input int val, input int wr);
        r_vld[i]  = vld;
        r_addr[i] = addr;
        r_val[i]  = val;
        r_wr[i]   = wr;
        waitc[i]  = 0;
    endtask

    task automatic model_clear();
        pivot = PINIT;
        gcnt  = 0;
        ccnt  = 0;
        for (int i = 0; i < 8; i++) begin
            sched_valid[i] = 0;
            sched_id[i]    = 0;
        end
        for (int i = 0; i < NC; i++) waitc[i] = 0;
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NC; i++) begin
            requests[i*REQ_W +: REQ_W] = {4'(r_addr[i]), 8'(r_val[i]), 1'(r_wr[i]), 1'(r_vld[i])};
        end
    endtask

    // One clock cycle: entered just after a negedge, leaves just after the next one.
    task automatic step(input int hold_v, input int plm_v);
        int elig [NC];
        int win;
        int ne;
        int idx;
        int s;
        longint exp_in;
        hold       = 1'(hold_v);
        plm_output = 8'(plm_v);
        drive_reqs();
        #1;
        win = -1;
        ne  = 0;
        for (int i = 0; i < NC; i++) begin
            elig[i] = (r_vld[i] != 0) && (r_addr[i] / SPAN == BID);
            ne += elig[i];
        end
        if (hold_v == 0) begin
            for (int k = 0; k < NC; k++) begin
                idx = (pivot + k) % NC;
                if (win < 0 && elig[idx] != 0) win = idx;
            end
        end
        check_eq("acks", 64'(acks), (win >= 0) ? 64'(1 << win) : 64'd0);
        check_eq("plm_en", 64'(plm_en), (win >= 0) ? 64'd1 : 64'd0);
        exp_in = 0;
        if (win >= 0) begin
            exp_in = ((r_addr[win] % SPAN) << (VW + 1)) + (r_val[win] << 1) + r_wr[win];
        end
        check_eq("plm_input", 64'(plm_input), 64'(exp_in));
        s = cyc % 8;
        check_eq("rsp_valid", 64'(rsp_valid), (sched_valid[s] != 0) ? 64'(1 << sched_id[s]) : 64'd0);
        check_eq("rsp_data", 64'(rsp_data), (sched_valid[s] != 0) ? 64'(plm_v) : 64'd0);
`ifdef RR_BANK_ARB_PERF_EN
        check_eq("grant_count", 64'(grant_count), 64'(gcnt));
        check_eq("conflict_count", 64'(conflict_count), 64'(ccnt));
`else
        check_eq("grant_count", 64'(grant_count), 64'd0);
        check_eq("conflict_count", 64'(conflict_count), 64'd0);
`endif
        if (win >= 0) begin
            check_eq("starvation", (waitc[win] <= NC - 1) ? 64'd1 : 64'd0, 64'd1);
            waitc[win] = 0;
            for (int i = 0; i < NC; i++) begin
                if (i != win && elig[i] != 0) waitc[i]++;
            end
        end
        sched_valid[s] = 0;
        if (win >= 0) begin
            pivot = (win + 1) % NC;
            if (r_wr[win] == 0) begin
                sched_valid[(cyc + LAT) % 8] = 1;
                sched_id[(cyc + LAT) % 8]    = win;
            end
            if (gcnt < 64'hFFFF_FFFF) gcnt++;
        end
        if (ne >= 2 && hold_v == 0 && ccnt < 64'hFFFF_FFFF) ccnt++;
        last_win = win;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Entered just after a negedge; asserts reset asynchronously mid-cycle.
    task automatic do_reset(input int cycles);
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        check_eq("rst_acks", 64'(acks), 64'd0);
        check_eq("rst_plm_en", 64'(plm_en), 64'd0);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_rsp_data", 64'(rsp_data), 64'd0);
        check_eq("rst_grant_count", 64'(grant_count), 64'd0);
        check_eq("rst_conflict_count", 64'(conflict_count), 64'd0);
        repeat (cycles) begin
            @(posedge clk);
            cyc++;
            #1;
            check_eq("rst_hold_acks", 64'(acks), 64'd0);
            check_eq("rst_hold_rsp", 64'(rsp_valid), 64'd0);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b0;
        hold       = 1'b0;
        requests   = '0;
        plm_output = '0;
        cyc        = 0;
        last_win   = -1;
        for (int i = 0; i < NC; i++) set_req(i, 1, 8 + i, 16 * i + 1, 0);
        model_clear();
        @(negedge clk);
        do_reset(2);

        // All consumers continuously requesting this bank: strict rotation
        for (int i = 0; i < NC; i++) set_req(i, 1, 8 + 2 * i, $urandom_range(0, 255), i % 2);
        repeat (8) step(0, $urandom_range(0, 255));

        // Only consumer 2 eligible: skip over 0 and 1, then pivot lands on 3
        for (int i = 0; i < NC; i++) set_req(i, 0, 0, 0, 1);
        set_req(2, 1, 12, 8'h3C, 1);
        step(0, 0);
        set_req(2, 0, 0, 0, 1);
        set_req(1, 1, 9, 8'h11, 1);
        set_req(3, 1, 10, 8'h33, 1);
        step(0, 0);

        // Bank filtering: addr 0x3 belongs to bank 0, addr 0xB to bank 1
        for (int i = 0; i < NC; i++) set_req(i, 0, 0, 0, 1);
        set_req(0, 1, 4'h3, 8'h77, 1);
        set_req(1, 1, 4'hB, 8'h66, 1);
        step(0, 0);

        // Read then write by consumer 1; only the read returns, two cycles later
        for (int i = 0; i < NC; i++) set_req(i, 0, 0, 0, 1);
        set_req(1, 1, 4'hA, 8'h10, 0);
        step(0, 8'h00);
        set_req(1, 1, 4'hA, 8'h20, 1);
        step(0, 8'h11);
        set_req(1, 0, 0, 0, 1);
        step(0, 8'hA5);
        step(0, 8'hC3);

        // Hold freezes new grants while an in-flight read still completes
        for (int i = 0; i < NC; i++) set_req(i, 0, 0, 0, 1);
        set_req(0, 1, 4'h9, 8'h42, 0);
        step(0, 0);
        for (int i = 0; i < NC; i++) set_req(i, 1, 8 + i, 8'h50 + i, 1);
        repeat (3) step(1, $urandom_range(0, 255));
        step(0, 0);

        // Reset with a read outstanding: response dropped, pivot back to init
        for (int i = 0; i < NC; i++) set_req(i, 0, 0, 0, 1);
        set_req(1, 1, 4'hC, 8'h99, 0);
        step(0, 0);
        for (int i = 0; i < NC; i++) set_req(i, 1, 8 + i, 8'h60 + i, 1);
        do_reset(1);
        repeat (4) step(0, $urandom_range(0, 255));

        // Randomized traffic with consumer handshake and occasional hold
        for (int i = 0; i < NC; i++) new_req(i);
        for (int n = 0; n < 500; n++) begin
            step(($urandom_range(0, 7) == 0) ? 1 : 0, $urandom_range(0, 255));
            for (int i = 0; i < NC; i++) begin
                if (last_win == i || r_vld[i] == 0 || (r_addr[i] / SPAN != BID)) begin
                    if (last_win == i || $urandom_range(0, 1) == 1) new_req(i);
                end
            end
            if (n == 250) begin
                do_reset(1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_bank_arbiter.md
Name: rr_bank_arbiter

Overview:
- Work-conserving round-robin arbiter for one port of one PLM bank.
- Each cycle it grants at most one eligible consumer request, which must be valid and target this bank.
- It drives the bank's PLM input, acknowledges the winner, and routes the PLM read data back to the granted consumer after a fixed PLM latency.
- A banked memory subsystem instantiates one per (bank, port), replacing blind pivot rotation with skip-to-next-eligible scheduling.

Parameters:
- ADDR_WIDTH, 4, full consumer address width, bank bits at MSBs.
- VALUE_WIDTH, 8, data word width.
- NCONSUMERS, 2, number of requesters (>=2).
- NBANKS, 1, number of banks; NUM_BANK_BITS = $clog2(NBANKS).
- BANK_ID, 0, bank index this instance serves.
- PIVOT_INIT, 0, pivot value after reset (< NCONSUMERS).
- PLM_LATENCY, 1, cycles from PLM input edge to valid plm_output (1..4).

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  reset; asynchronous, active-low (asserted at 0).
- requests  in  REQ_WIDTH x NCONSUMERS  {addr, value, wr, valid}, REQ_WIDTH = ADDR_WIDTH+VALUE_WIDTH+2.
- hold  in  1  freeze scheduling this cycle.
- acks  out  NCONSUMERS  one-hot grant, combinational.
- plm_en  out  1  PLM access this cycle.
- plm_input  out  PLM_INPUT_WIDTH  {local addr, value, wr}, PLM_INPUT_WIDTH = ADDR_WIDTH-NUM_BANK_BITS+VALUE_WIDTH+1.
- plm_output  in  VALUE_WIDTH  PLM read data.
- rsp_valid  out  NCONSUMERS  one-hot read response strobe.
- rsp_data  out  VALUE_WIDTH  read data, broadcast.
- grant_count  out  32  perf counter (optional feature).
- conflict_count  out  32  perf counter (optional feature).

Behaviour:
- Eligibility: request valid bit = 1 and addr[ADDR_WIDTH-1 -: NUM_BANK_BITS] == BANK_ID.
  - When NBANKS == 1, every valid request is eligible.
- Selection (combinational, cycle t):
  - Scan from pivot upward, wrapping modulo NCONSUMERS.
  - The first eligible index wins.
  - If none is eligible, or hold = 1: acks = 0, plm_en = 0, plm_input = 0.
- Drive on grant:
  - acks[win] = 1.
  - plm_en = 1.
  - plm_input = request bits excluding valid and bank bits.
- Consumer handshake: a consumer holds its request stable until it sees its ack high at a rising edge; it may drop or change the request on the next cycle.
- Pivot update (edge at end of t):
  - On grant: pivot <= (win+1) mod NCONSUMERS, with explicit wrap for non-power-of-2 NCONSUMERS.
  - Otherwise pivot is unchanged.
  - Guarantee: no eligible consumer waits more than NCONSUMERS-1 grants.
- Response pipeline: PLM_LATENCY-stage shift register of {is_read, id}.
  - Stage 0 is loaded with {plm_en & ~wr, win}.
  - In cycle t+PLM_LATENCY: rsp_valid[id] = is_read and rsp_data = plm_output.
  - Otherwise rsp_valid = 0 and rsp_data = 0.
- Writes produce no response.
- Back-to-back grants are allowed every cycle; the pipeline is fully overlapped.
- hold affects only new grants; in-flight reads still complete.
- Reset (asynchronous):
  - pivot = PIVOT_INIT; pipeline cleared; counters cleared.
  - Registered outputs are 0.
  - Reads in flight at reset are dropped with no rsp_valid.
  - Combinational outputs follow from the cleared state: acks = 0 and plm_en = 0 while reset = 0.
- Simultaneous events: a consumer may receive an ack for a new request in the same cycle as rsp_valid for an older one.

Optional Feature:
- RR_BANK_ARB_PERF_EN defined:
  - grant_count increments on every cycle with plm_en = 1.
  - conflict_count increments when two or more consumers are eligible and hold = 0.
  - Both saturate at 2^32-1 and clear on reset.
- Undefined: both outputs are tied to 0 and no counter flops are generated.

Decomposition:
- Shared package rr_sched_pkg holds:
  - REQ_WIDTH and PLM_INPUT_WIDTH computation functions.
  - Request field offset constants (VALID_BIT = 0, WR_BIT = 1, value and addr offsets).
  - typedef rsp_tag_t {is_read, id}.
- One sub-module is natural: rr_priority_pick.
  - Combinational: eligible vector and pivot in; one-hot winner, index and any out.
  - Implemented as a double-width rotate plus priority encoder.

Test Plan:
- NCONSUMERS=4, all requests valid to BANK_ID, hold=0 for 8 cycles, pivot reset 0 -> acks sequence 0,1,2,3,0,1,2,3; plm_en=1 every cycle.
- Only consumer 2 valid, pivot 0 -> granted in first cycle (skip 0,1); pivot becomes 3.
- NBANKS=2, BANK_ID=1: consumer 0 requests addr 0x3, consumer 1 requests addr 0xB -> only consumer 1 granted; plm_input local addr 0x3.
- PLM_LATENCY=2: read by consumer 1 at cycle 5 with PLM returning 0xA5 -> rsp_valid[1]=1, rsp_data=0xA5 at cycle 7; a write at cycle 6 -> no rsp at 8.
- hold=1 for 3 cycles with pending requests -> acks=0, plm_en=0, pivot unchanged; an in-flight read still responds.
- Assert reset mid-flight with a read outstanding (LATENCY=2) -> no rsp_valid; pivot=PIVOT_INIT; with RR_BANK_ARB_PERF_EN defined, counters read 0.
